intersection_monitor: RTL

- Synthesizable, parametrised runtime monitor for an N-channel signalised intersection.
- Instantiated alongside the intersection controller. Observes the per-channel green and request vectors.
- Records per-channel service coverage, conflicting-green violations, all-red clearance violations and request starvation as sticky status flags.
- Successor to the fixed four-channel formal cover set: same coverage intent, now in RTL, with arbitrary channel count and added safety/liveness checks.

---
 rtl/intersection_monitor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/intersection_monitor.sv
// Runtime monitor for an N-channel signalised intersection: service coverage,
// conflicting greens, all-red clearance and request starvation as sticky flags.
module intersection_monitor #(
  parameter int                         N_CHAN        = 4,
  parameter logic [N_CHAN*N_CHAN-1:0]   CONFLICT_MASK = 16'h591E,
  parameter int                         CLEAR_GAP     = 2,
  parameter int                         MAX_WAIT      = 64,
  parameter int                         IDX_W         = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [N_CHAN-1:0] green,
  input  logic [N_CHAN-1:0] request,
  output logic [N_CHAN-1:0] served,
  output logic              all_served,
  output logic              conflict,
  output logic              conflict_pulse,
  output logic [IDX_W-1:0]  conflict_i,
  output logic [IDX_W-1:0]  conflict_j,
  output logic              clearance_err,
  output logic [N_CHAN-1:0] starve
);

  localparam int GAP_W  = (CLEAR_GAP < 1) ? 1 : $clog2(CLEAR_GAP + 1);
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(CLEAR_GAP);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [N_CHAN-1:0] green_prev_r;
  logic [GAP_W-1:0]  gap_r       [N_CHAN];
  logic [WAIT_W-1:0] wait_r      [N_CHAN];
  logic [GAP_W-1:0]  gap_next_s  [N_CHAN];
  logic [WAIT_W-1:0] wait_base_s [N_CHAN];
  logic [WAIT_W-1:0] wait_next_s [N_CHAN];
  logic [N_CHAN-1:0] rise_s;
  logic [N_CHAN-1:0] served_next_s;
  logic [N_CHAN-1:0] starve_hit_s;
  logic              hit_s;
  logic              conf_now_s;
  logic              clr_now_s;
  logic              capture_s;
  logic [IDX_W-1:0]  ci_s;
  logic [IDX_W-1:0]  cj_s;

  // Conflicting-green detection; the first hit in (i, then j) order wins the index capture
  always_comb begin
    hit_s      = 1'b0;
    conf_now_s = 1'b0;
    ci_s       = {IDX_W{1'b0}};
    cj_s       = {IDX_W{1'b0}};
    for (int i = 0; i < N_CHAN; i++) begin
      for (int j = i + 1; j < N_CHAN; j++) begin
        hit_s      = green[i] & green[j] & CONFLICT_MASK[i*N_CHAN+j];
        ci_s       = (hit_s && !conf_now_s) ? IDX_W'(i) : ci_s;
        cj_s       = (hit_s && !conf_now_s) ? IDX_W'(j) : cj_s;
        conf_now_s = conf_now_s | hit_s;
      end
    end
    capture_s = conf_now_s & (clear | ~conflict);
  end

  // Clearance check: a rising green against any conflicting channel that went idle too recently
  always_comb begin
    rise_s    = green & ~green_prev_r;
    clr_now_s = 1'b0;
    for (int j = 0; j < N_CHAN; j++) begin
      for (int i = 0; i < N_CHAN; i++) begin
        clr_now_s = clr_now_s | (rise_s[j] & CONFLICT_MASK[i*N_CHAN+j] & (i != j)
                                 & (gap_r[i] < GAP_MAX));
      end
    end
  end

  // Per-channel next state; clear restarts counting from zero but same-cycle events still set
  always_comb begin
    for (int i = 0; i < N_CHAN; i++) begin
      served_next_s[i] = (served[i] & ~clear) | green[i];
      wait_base_s[i]   = clear ? {WAIT_W{1'b0}} : wait_r[i];
      wait_next_s[i]   = (request[i] & ~green[i])
                         ? ((wait_base_s[i] == WAIT_MAX) ? WAIT_MAX : wait_base_s[i] + WAIT_W'(1))
                         : {WAIT_W{1'b0}};
      starve_hit_s[i]  = (wait_next_s[i] == WAIT_MAX);
      gap_next_s[i]    = green[i] ? {GAP_W{1'b0}}
                         : ((clear || (gap_r[i] == GAP_MAX)) ? GAP_MAX : gap_r[i] + GAP_W'(1));
    end
  end

  // Registered outputs, sticky flags and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      green_prev_r   <= {N_CHAN{1'b0}};
      served         <= {N_CHAN{1'b0}};
      all_served     <= 1'b0;
      conflict       <= 1'b0;
      conflict_pulse <= 1'b0;
      conflict_i     <= {IDX_W{1'b0}};
      conflict_j     <= {IDX_W{1'b0}};
      clearance_err  <= 1'b0;
      starve         <= {N_CHAN{1'b0}};
      for (int i = 0; i < N_CHAN; i++) begin
        gap_r[i]  <= GAP_MAX;
        wait_r[i] <= {WAIT_W{1'b0}};
      end
    end else begin
      green_prev_r   <= green;
      served         <= served_next_s;
      all_served     <= &served_next_s;
      conflict       <= (conflict & ~clear) | conf_now_s;
      conflict_pulse <= conf_now_s;
      clearance_err  <= (clearance_err & ~clear) | clr_now_s;
      starve         <= (starve & ~{N_CHAN{clear}}) | starve_hit_s;
      if (capture_s) begin
        conflict_i <= ci_s;
        conflict_j <= cj_s;
      end else if (clear) begin
        conflict_i <= {IDX_W{1'b0}};
        conflict_j <= {IDX_W{1'b0}};
      end else begin
        conflict_i <= conflict_i;
        conflict_j <= conflict_j;
      end
      for (int i = 0; i < N_CHAN; i++) begin
        gap_r[i]  <= gap_next_s[i];
        wait_r[i] <= wait_next_s[i];
      end
    end
  end

endmodule
